sdet: RTL and testbench

- Serial bit-sequence detector, Moore style, default pattern "111".
- Samples one input bit per rising clock edge. Tracks how much of the pattern's prefix has matched using a small state register.
- Asserts o for the full cycle after the final pattern bit is sampled.
- Used as a leaf control block on a single-bit serial stream.

---
 rtl/sdet.sv | 101 ++++++++++
 tb/tb_sdet.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sdet.sv
// Moore serial bit-sequence detector; transitions are derived from PATTERN at elaboration time.
// Define SDET_MATCH_CNT_EN to add the saturating 8-bit match_cnt output.
module sdet #(
  parameter int                     PATTERN_LEN = 3,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 3'b111,
  parameter logic                   OVERLAP     = 1'b1
) (
  input  logic       ck,
  input  logic       reset,
  input  logic       i,
`ifdef SDET_MATCH_CNT_EN
  output logic [7:0] match_cnt,
`endif
  output logic       o
);

  localparam int N  = PATTERN_LEN;
  localparam int SW = $clog2(N + 1);
  localparam int NS = 1 << SW;
  localparam logic [8:0] PAT9 = 9'(PATTERN);

  // Pattern bit m in arrival order (m = 0 is the first bit received).
  function automatic logic pbit(input int m);
    logic [8:0] s;
    s = PAT9 >> (N - 1 - m);
    return s[0];
  endfunction

  // Longest pattern prefix that is a suffix of (matched prefix of length k) + b.
  function automatic int kmp_next(input int k, input logic b);
    int   hbits;
    int   len;
    int   best;
    logic ok;
    int   hv;
    hbits = 0;
    best  = 0;
    if (k > N) return 0;
    if (k == N && !OVERLAP) return (b == pbit(0)) ? 1 : 0;
    len = (k == N) ? N + 1 : k + 1;
    for (int t = 0; t < 9; t++) begin
      if (t < len - 1) hbits = hbits | (int'(pbit(t)) << t);
    end
    hbits = hbits | (int'(b) << (len - 1));
    for (int j = 1; j <= 8; j++) begin
      if (j <= N && j <= len) begin
        ok = 1'b1;
        for (int m = 0; m < 8; m++) begin
          if (m < j) begin
            hv = (hbits >> (len - j + m)) & 1;
            if (hv != int'(pbit(m))) ok = 1'b0;
          end
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

  // Unused encodings above S_N resolve to S0 through kmp_next.
  logic [SW-1:0] nxt0 [NS];
  logic [SW-1:0] nxt1 [NS];

  for (genvar k = 0; k < NS; k++) begin : g_tbl
    assign nxt0[k] = SW'(kmp_next(k, 1'b0));
    assign nxt1[k] = SW'(kmp_next(k, 1'b1));
  end

  logic [SW-1:0] state_q;
  logic [SW-1:0] state_d;

  always_comb begin
    state_d = nxt0[state_q];
    if (i) state_d = nxt1[state_q];
  end

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) state_q <= '0;
    else        state_q <= state_d;
  end

  assign o = (state_q == SW'(N));

`ifdef SDET_MATCH_CNT_EN
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_d == SW'(N) && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) cnt_q <= 8'h00;
    else        cnt_q <= cnt_d;
  end

  assign match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_sdet.sv
// Bench for sdet: three instances (111 overlap, 111 non-overlap, 1011 overlap) driven in parallel
// and compared every cycle against a history-window model, plus directed literal expectations.
module tb_sdet;
  logic ck    = 1'b0;
  logic reset = 1'b1;
  logic i     = 1'b0;
  logic oa, ob, oc;
`ifdef SDET_MATCH_CNT_EN
  logic [7:0] cnt_a, cnt_b, cnt_c;
`endif
  logic en = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 ck = ~ck;

  sdet u_a (
    .ck(ck), .reset(reset), .i(i),
`ifdef SDET_MATCH_CNT_EN
    .match_cnt(cnt_a),
`endif
    .o(oa)
  );

  sdet #(.PATTERN_LEN(3), .PATTERN(3'b111), .OVERLAP(1'b0)) u_b (
    .ck(ck), .reset(reset), .i(i),
`ifdef SDET_MATCH_CNT_EN
    .match_cnt(cnt_b),
`endif
    .o(ob)
  );

  sdet #(.PATTERN_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1)) u_c (
    .ck(ck), .reset(reset), .i(i),
`ifdef SDET_MATCH_CNT_EN
    .match_cnt(cnt_c),
`endif
    .o(oc)
  );

  // Model: a match is "the last LEN bits seen since reset (or since the
  // previous match when non-overlapping) equal the pattern".
  function automatic int mlen(input int m);
    return (m == 2) ? 4 : 3;
  endfunction
  function automatic int mpat(input int m);
    return (m == 2) ? 'b1011 : 'b111;
  endfunction
  function automatic logic movl(input int m);
    return (m != 1);
  endfunction

  int         hist [3];
  int         avail [3];
  int         nh [3];
  logic [2:0] hit_now;
  logic [2:0] exp_o;
  int         exp_cnt [3];

  always_comb begin
    hit_now = '0;
    for (int m = 0; m < 3; m++) begin
      nh[m] = ((hist[m] << 1) | int'(i)) & ((1 << mlen(m)) - 1);
      hit_now[m] = (avail[m] + 1 >= mlen(m)) && (nh[m] == mpat(m));
    end
  end

  always @(posedge ck or negedge reset) begin
    if (!reset) begin
      for (int m = 0; m < 3; m++) begin
        hist[m]    <= 0;
        avail[m]   <= 0;
        exp_cnt[m] <= 0;
      end
      exp_o <= '0;
    end else begin
      for (int m = 0; m < 3; m++) begin
        hist[m]  <= nh[m];
        exp_o[m] <= hit_now[m];
        if (hit_now[m] && !movl(m)) avail[m] <= 0;
        else                        avail[m] <= (avail[m] >= 8) ? 8 : avail[m] + 1;
        if (hit_now[m] && exp_cnt[m] < 255) exp_cnt[m] <= exp_cnt[m] + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge ck) begin
    if (en) begin
      chk("o_a", 8'(oa), 8'(exp_o[0]));
      chk("o_b", 8'(ob), 8'(exp_o[1]));
      chk("o_c", 8'(oc), 8'(exp_o[2]));
`ifdef SDET_MATCH_CNT_EN
      chk("cnt_a", cnt_a, 8'(exp_cnt[0]));
      chk("cnt_b", cnt_b, 8'(exp_cnt[1]));
      chk("cnt_c", cnt_c, 8'(exp_cnt[2]));
`endif
    end
  end

  // Drive one bit, then check {a,b,c} at the following falling edge.
  task automatic step(input logic b, input logic [2:0] e, input string nm);
    i = b;
    @(posedge ck);
    @(negedge ck);
    chk({nm, "_dut"}, {5'b0, oa, ob, oc}, {5'b0, e});
    chk({nm, "_model"}, {5'b0, exp_o[0], exp_o[1], exp_o[2]}, {5'b0, e});
  endtask

  task automatic do_reset();
    i = 1'b0;
    reset = 1'b0;
    @(posedge ck);
    @(negedge ck);
    chk("rst_o", {5'b0, oa, ob, oc}, 8'h00);
`ifdef SDET_MATCH_CNT_EN
    chk("rst_cnt", cnt_a | cnt_b | cnt_c, 8'h00);
`endif
    reset = 1'b1;
  endtask

  task automatic run_seq(input logic [15:0] bits, input int n,
                         input logic [15:0] ea, input logic [15:0] eb,
                         input logic [15:0] ec, input string nm);
    for (int k = n - 1; k >= 0; k--) begin
      step(bits[k], {ea[k], eb[k], ec[k]}, nm);
    end
  endtask

  initial begin
    #1;
    do_reset();
    en = 1'b1;

    // Reset then idle.
    step(1'b0, 3'b000, "idle");
    step(1'b0, 3'b000, "idle");

    // Default 111 detection.
    do_reset();
    run_seq(16'b111, 3, 16'b001, 16'b001, 16'b000, "det111");

    // Break and overlap: 1,1,0,1,1,1,1.
    do_reset();
    run_seq(16'b1101111, 7, 16'b0000011, 16'b0000010, 16'b0000100, "brk_ovl");

    // Asynchronous reset mid-match.
    do_reset();
    run_seq(16'b111, 3, 16'b001, 16'b001, 16'b000, "pre_arst");
    #2 reset = 1'b0;
    #1 chk("arst_o", {5'b0, oa, ob, oc}, 8'h00);
`ifdef SDET_MATCH_CNT_EN
    chk("arst_cnt", cnt_a | cnt_b | cnt_c, 8'h00);
`endif
    @(negedge ck);
    reset = 1'b1;
    run_seq(16'b111, 3, 16'b001, 16'b001, 16'b000, "post_arst");

    // Pattern 1011 on instance c: 1,0,1,0,1,1,0,1,1.
    do_reset();
    run_seq(16'b101011011, 9, 16'b0, 16'b0, 16'b000001001, "pat1011");

    // Long run of ones: counter saturation on a, 100 non-overlapping hits on b.
    do_reset();
    i = 1'b1;
    repeat (300) @(negedge ck);
`ifdef SDET_MATCH_CNT_EN
    chk("sat_cnt_a", cnt_a, 8'hFF);
    chk("sat_cnt_b", cnt_b, 8'd100);
    chk("sat_cnt_c", cnt_c, 8'h00);
`endif
    chk("ones_o", {5'b0, oa, oc}, 8'b010);
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
